// File: rtl/mmio_uart_tx_if.sv
// Store-port snoop and UART status bundle between the core-side top level
// and mmio_uart_tx. Signal names follow the core's datapath names.
interface mmio_uart_tx_if #(
    parameter int FIFO_DEPTH = 8
);
    logic                          MemWrite;
    logic [31:0]                   ALUResult;
    logic [31:0]                   WriteData;
    logic                          txd;
    logic                          tx_busy;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overflow;
    logic [31:0]                   status;

    modport master (
        output MemWrite, ALUResult, WriteData,
        input  txd, tx_busy, fifo_count, overflow, status
    );

    modport slave (
        input  MemWrite, ALUResult, WriteData,
        output txd, tx_busy, fifo_count, overflow, status
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter snooping the core's store port.
// Stores to ADDR_TX queue a byte; stores to ADDR_CTRL with bit0 set clear
// the sticky overflow flag.
//
// state | meaning
// IDLE  | txd high, waiting for a queued byte
// START | start bit (txd low) for CLKS_PER_BIT cycles
// DATA  | 8 data bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (txd high); chains straight into START if bytes remain
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] ADDR_TX      = 32'h0000_0100,
    parameter logic [31:0] ADDR_CTRL    = 32'h0000_0104
) (
    input logic         clk,
    input logic         reset,
    mmio_uart_tx_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic push_req, ctrl_clr, push_ok, pop, baud_end, fifo_empty, fifo_full;

    assign push_req   = bus.MemWrite && (bus.ALUResult == ADDR_TX);
    assign ctrl_clr   = bus.MemWrite && (bus.ALUResult == ADDR_CTRL) && bus.WriteData[0];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign baud_end   = (baud_q == BAUD_LAST);

    // FIFO bookkeeping; a pop in the same cycle frees room for a push into a full FIFO
    always_comb begin
        push_ok = push_req && (!fifo_full || pop);
        wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d    = pop ? rd_q + 1'b1 : rd_q;
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (ctrl_clr)
            ovf_d = 1'b0;
        if (push_req && !push_ok)
            ovf_d = 1'b1;
    end

    // Transmit FSM; txd is registered from the next state so it never glitches
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_q];
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
        endcase
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    // Control state, cleared asynchronously so txd returns high without a clock
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            txd_q   <= 1'b1;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Byte storage needs no reset; the pointers and count define validity
    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_q] <= bus.WriteData[7:0];
    end

    assign bus.txd        = txd_q;
    assign bus.tx_busy    = (state_q != IDLE);
    assign bus.fifo_count = count_q;
    assign bus.overflow   = ovf_q;
    assign bus.status     = {28'b0, ovf_q, fifo_full, fifo_empty, (state_q != IDLE)};
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A serial line monitor decodes txd independently into a byte queue that is
// compared against the bytes each scenario expects to see transmitted.
module tb_mmio_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam logic [31:0] A_TX   = 32'h0000_0100;
    localparam logic [31:0] A_CTRL = 32'h0000_0104;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mmio_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

    mmio_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .ADDR_TX     (A_TX),
        .ADDR_CTRL   (A_CTRL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    bit         mon_en = 1'b0;
    logic [7:0] rx_q[$];
    int         rx_t[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: samples each bit near its centre, checks the stop bit
    initial begin : monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && reset && bus.txd === 1'b0) begin
                rx_t.push_back(cyc);
                repeat (CPB / 2) @(negedge clk);
                for (int j = 0; j < 8; j++) begin
                    repeat (CPB) @(negedge clk);
                    b[j] = bus.txd;
                end
                repeat (CPB) @(negedge clk);
                n_cmp++;
                if (bus.txd !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stop_bit: txd=%b required 1", bus.txd);
                end
                rx_q.push_back(b);
                repeat (CPB - 1 - CPB / 2) @(negedge clk);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.MemWrite  = 1'b1;
        bus.ALUResult = a;
        bus.WriteData = d;
        step();
        bus.MemWrite  = 1'b0;
        bus.WriteData = $urandom;
    endtask

    task automatic wait_drain(input int n, input string name);
        int k;
        k = 0;
        while ((rx_q.size() < n || bus.tx_busy !== 1'b0) && k < 60 * n + 100) begin
            step();
            k++;
        end
        n_cmp++;
        if (rx_q.size() < n || bus.tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d frames busy=%b, required %0d frames and idle",
                     name, rx_q.size(), bus.tx_busy, n);
        end
    endtask

    task automatic check_bytes(input logic [7:0] exp_q[$], input string name);
        n_cmp++;
        if (rx_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d bytes, required %0d", name, rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_cmp++;
            if (rx_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s_byte%0d: got %02h required %02h", name, i, rx_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.MemWrite  = 1'($urandom);
            bus.ALUResult = (i == 0) ? A_TX : ((i == 1) ? A_CTRL : 32'($urandom));
            bus.WriteData = $urandom;
            step();
            n_cmp++;
            if (bus.txd !== 1'b1 || bus.tx_busy !== 1'b0 || bus.fifo_count !== 3'd0 ||
                bus.overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: txd=%b busy=%b count=%0d ovf=%b, required 1 0 0 0",
                         bus.txd, bus.tx_busy, bus.fifo_count, bus.overflow);
            end
            n_cmp++;
            if (bus.status !== 32'h2) begin
                n_fail++;
                $display("FAIL reset_status: got %08h required 00000002", bus.status);
            end
        end
        bus.MemWrite = 1'b0;
        reset = 1'b1;
        step();
    endtask

    task automatic test_single();
        logic [9:0] fr;
        logic [7:0] exp_q[$];
        rx_q.delete();
        rx_t.delete();
        mon_en = 1'b1;
        fr = {1'b1, 8'h55, 1'b0};
        store(A_TX, 32'h0000_0155);
        n_cmp++;
        if (bus.fifo_count !== 3'd1 || bus.txd !== 1'b1) begin
            n_fail++;
            $display("FAIL single_push: count=%0d txd=%b, required 1 and 1", bus.fifo_count, bus.txd);
        end
        for (int k = 1; k <= 41; k++) begin
            step();
            n_cmp++;
            if (bus.txd !== ((k <= 40) ? fr[(k - 1) / CPB] : 1'b1)) begin
                n_fail++;
                $display("FAIL single_txd_k%0d: got %b required %b", k, bus.txd,
                         (k <= 40) ? fr[(k - 1) / CPB] : 1'b1);
            end
            if (k == 1 || k == 40 || k == 41) begin
                n_cmp++;
                if (bus.tx_busy !== (k <= 40)) begin
                    n_fail++;
                    $display("FAIL single_busy_k%0d: got %b required %b", k, bus.tx_busy, k <= 40);
                end
            end
            if (k == 1) begin
                n_cmp++;
                if (bus.fifo_count !== 3'd0) begin
                    n_fail++;
                    $display("FAIL single_pop: count=%0d required 0", bus.fifo_count);
                end
            end
        end
        exp_q = '{8'h55};
        check_bytes(exp_q, "single");
    endtask

    task automatic test_back_to_back();
        int maxc;
        logic [7:0] exp_q[$];
        rx_q.delete();
        rx_t.delete();
        maxc = 0;
        store(A_TX, 32'h41);
        if (int'(bus.fifo_count) > maxc) maxc = int'(bus.fifo_count);
        store(A_TX, 32'h42);
        for (int k = 0; k < 120 && !(rx_q.size() >= 2 && bus.tx_busy === 1'b0); k++) begin
            if (int'(bus.fifo_count) > maxc) maxc = int'(bus.fifo_count);
            step();
        end
        n_cmp++;
        if (maxc > 1) begin
            n_fail++;
            $display("FAIL b2b_maxcount: got %0d required <=1", maxc);
        end
        exp_q = '{8'h41, 8'h42};
        check_bytes(exp_q, "b2b");
        n_cmp++;
        if (rx_t.size() < 2 || rx_t[1] - rx_t[0] != 10 * CPB) begin
            n_fail++;
            $display("FAIL b2b_gap: frame spacing %0d required %0d",
                     (rx_t.size() < 2) ? -1 : rx_t[1] - rx_t[0], 10 * CPB);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_q[$];
        rx_q.delete();
        for (int v = 1; v <= 6; v++) store(A_TX, 32'(v));
        n_cmp++;
        if (bus.overflow !== 1'b1 || bus.fifo_count !== 3'd4) begin
            n_fail++;
            $display("FAIL ovf_set: ovf=%b count=%0d, required 1 and 4", bus.overflow, bus.fifo_count);
        end
        n_cmp++;
        if (bus.status !== 32'hD) begin
            n_fail++;
            $display("FAIL ovf_status: got %08h required 0000000d", bus.status);
        end
        step();
        step();
        n_cmp++;
        if (bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %b required 1", bus.overflow);
        end
        store(A_CTRL, 32'h1);
        n_cmp++;
        if (bus.overflow !== 1'b0 || bus.status[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: ovf=%b status=%08h, required 0", bus.overflow, bus.status);
        end
        wait_drain(5, "ovf");
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        check_bytes(exp_q, "ovf");
    endtask

    task automatic test_decode();
        int bad;
        rx_q.delete();
        store(32'h0000_0000, 32'h5A);
        store(32'h0000_0101, 32'h5B);
        store(32'h0001_0100, 32'h5C);
        bus.MemWrite  = 1'b0;
        bus.ALUResult = A_TX;
        bus.WriteData = 32'h5D;
        step();
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            if (bus.txd !== 1'b1 || bus.fifo_count !== 3'd0 || bus.tx_busy !== 1'b0) bad++;
            step();
        end
        n_cmp++;
        if (bad != 0 || rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL decode_nopush: %0d bad cycles, %0d frames, required 0 and 0", bad, rx_q.size());
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [31:0] a;
        for (int it = 0; it < 4; it++) begin
            int n;
            rx_q.delete();
            exp_q.delete();
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                logic [7:0] d;
                if ($urandom_range(0, 2) == 0) begin
                    a = $urandom;
                    if (a == A_TX || a == A_CTRL) a = a ^ 32'h8000_0000;
                    store(a, $urandom);
                end
                if ($urandom_range(0, 3) == 0) begin
                    bus.ALUResult = A_TX;
                    bus.WriteData = $urandom;
                    step();
                end
                d = 8'($urandom);
                exp_q.push_back(d);
                store(A_TX, {24'($urandom), d});
            end
            wait_drain(n, "rand");
            check_bytes(exp_q, "rand");
            n_cmp++;
            if (bus.overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_ovf: got %b required 0", bus.overflow);
            end
        end
    endtask

    task automatic test_midframe_reset();
        logic [7:0] b0;
        int bad;
        mon_en = 1'b0;
        b0 = 8'($urandom) & 8'hF7;
        store(A_TX, {24'h0, b0});
        store(A_TX, 32'($urandom));
        store(A_TX, 32'($urandom));
        repeat (16) step();
        n_cmp++;
        if (bus.txd !== 1'b0 || bus.fifo_count !== 3'd2) begin
            n_fail++;
            $display("FAIL mid_pre: txd=%b count=%0d, required 0 and 2", bus.txd, bus.fifo_count);
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.txd !== 1'b1 || bus.tx_busy !== 1'b0 || bus.fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_async: txd=%b busy=%b count=%0d, required 1 0 0",
                     bus.txd, bus.tx_busy, bus.fifo_count);
        end
        step();
        step();
        reset = 1'b1;
        bad = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (bus.txd !== 1'b1 || bus.tx_busy !== 1'b0 || bus.fifo_count !== 3'd0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL mid_after: %0d cycles not idle, required 0", bad);
        end
    endtask

    initial begin
        bus.MemWrite  = 1'b0;
        bus.ALUResult = 32'h0;
        bus.WriteData = 32'h0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_decode();
        test_random();
        test_midframe_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
